// File: rtl/vlc_bit_packer_if.sv
// vlc_bit_packer_if: codeword input and packed-word output bundle.
// VLC_PACKER_STATS_EN adds the bit_count/word_count statistics.
interface vlc_bit_packer_if #(
    parameter int WORD_W = 32,
    parameter int LEN_W  = 6
);
    logic [31:0]       vlc_code;
    logic [LEN_W-1:0]  vlc_length;
    logic              vlc_enable;
    logic              vlc_flush;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic [2:0]        out_bytes;
    logic              flush_done;
    logic              busy;
    logic              len_error;
`ifdef VLC_PACKER_STATS_EN
    logic [31:0]       bit_count;
    logic [15:0]       word_count;

    modport master (
        output vlc_code, vlc_length, vlc_enable, vlc_flush,
        input  out_data, out_valid, out_bytes, flush_done, busy,
        input  len_error, bit_count, word_count
    );
    modport slave (
        input  vlc_code, vlc_length, vlc_enable, vlc_flush,
        output out_data, out_valid, out_bytes, flush_done, busy,
        output len_error, bit_count, word_count
    );
`else
    modport master (
        output vlc_code, vlc_length, vlc_enable, vlc_flush,
        input  out_data, out_valid, out_bytes, flush_done, busy,
        input  len_error
    );
    modport slave (
        input  vlc_code, vlc_length, vlc_enable, vlc_flush,
        output out_data, out_valid, out_bytes, flush_done, busy,
        output len_error
    );
`endif
endinterface

// File: rtl/vlc_bit_packer.sv
// vlc_bit_packer: packs right-aligned VLC codewords MSB-first into 32-bit words.
// Optional macro VLC_PACKER_STATS_EN adds per-slice bit_count/word_count.
module vlc_bit_packer #(
    parameter int WORD_W = 32,
    parameter int LEN_W  = 6
) (
    input logic             clock,
    input logic             reset_n,
    vlc_bit_packer_if.slave bus
);
    typedef enum logic {RUN, FLUSH2} state_t;

    state_t            state_q, state_d;
    logic [63:0]       acc_q, acc_d;
    logic [5:0]        fill_q, fill_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [2:0]        out_bytes_q, out_bytes_d;
    logic              flush_done_q, flush_done_d;
    logic              busy_q, busy_d;
    logic              len_error_q, len_error_d;

    logic [LEN_W-1:0]  len_clamp;
    logic [LEN_W-1:0]  app_len;
    logic [31:0]       mask;
    logic [31:0]       code_m;
    logic [6:0]        shamt;
    logic [6:0]        new_fill;
    logic [63:0]       app_acc;

    function automatic logic [2:0] nbytes(input logic [6:0] n);
        logic [6:0] t;
        t = n + 7'd7;
        return t[5:3];
    endfunction

    // Clamp the length, mask the code and place it below the current fill.
    always_comb begin
        len_clamp = (bus.vlc_length > LEN_W'(32)) ? LEN_W'(32) : bus.vlc_length;
        app_len   = (state_q == RUN && bus.vlc_enable) ? len_clamp : '0;
        mask      = (app_len == LEN_W'(32)) ? 32'hFFFF_FFFF
                                            : ((32'd1 << app_len) - 32'd1);
        code_m    = bus.vlc_code & mask;
        new_fill  = 7'(fill_q) + 7'(app_len);
        shamt     = 7'd64 - new_fill;
        app_acc   = acc_q | (64'(code_m) << shamt);
    end

    // Next-state, accumulator update and registered output decode.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        fill_d       = fill_q;
        out_data_d   = '0;
        out_valid_d  = 1'b0;
        out_bytes_d  = 3'd0;
        flush_done_d = 1'b0;
        busy_d       = 1'b0;
        len_error_d  = len_error_q;
        unique case (state_q)
            RUN: begin
                if (bus.vlc_enable && bus.vlc_length > LEN_W'(32)) begin
                    len_error_d = 1'b1;
                end
                if (bus.vlc_flush) begin
                    if (new_fill == 7'd0) begin
                        flush_done_d = 1'b1;
                        acc_d        = '0;
                        fill_d       = '0;
                    end else if (new_fill <= 7'd32) begin
                        out_data_d   = app_acc[63:32];
                        out_valid_d  = 1'b1;
                        out_bytes_d  = nbytes(new_fill);
                        flush_done_d = 1'b1;
                        acc_d        = '0;
                        fill_d       = '0;
                    end else begin
                        out_data_d  = app_acc[63:32];
                        out_valid_d = 1'b1;
                        out_bytes_d = 3'd4;
                        acc_d       = app_acc << 32;
                        fill_d      = 6'(new_fill - 7'd32);
                        state_d     = FLUSH2;
                    end
                end else if (new_fill >= 7'd32) begin
                    out_data_d  = app_acc[63:32];
                    out_valid_d = 1'b1;
                    out_bytes_d = 3'd4;
                    acc_d       = app_acc << 32;
                    fill_d      = 6'(new_fill - 7'd32);
                end else begin
                    acc_d  = app_acc;
                    fill_d = new_fill[5:0];
                end
            end
            FLUSH2: begin
                busy_d       = 1'b1;
                out_data_d   = acc_q[63:32];
                out_valid_d  = 1'b1;
                out_bytes_d  = nbytes(7'(fill_q));
                flush_done_d = 1'b1;
                acc_d        = '0;
                fill_d       = '0;
                state_d      = RUN;
                if (bus.vlc_enable || bus.vlc_flush) begin
                    len_error_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State, accumulator and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            acc_q        <= '0;
            fill_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_bytes_q  <= 3'd0;
            flush_done_q <= 1'b0;
            busy_q       <= 1'b0;
            len_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_bytes_q  <= out_bytes_d;
            flush_done_q <= flush_done_d;
            busy_q       <= busy_d;
            len_error_q  <= len_error_d;
        end
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_bytes  = out_bytes_q;
    assign bus.flush_done = flush_done_q;
    assign bus.busy       = busy_q;
    assign bus.len_error  = len_error_q;

`ifdef VLC_PACKER_STATS_EN
    logic [31:0] bit_count_q, bit_count_d;
    logic [15:0] word_count_q, word_count_d;

    // Counters hold through flush_done, then restart for the next slice.
    always_comb begin
        bit_count_d  = (flush_done_q ? 32'd0 : bit_count_q) + 32'(app_len);
        word_count_d = (flush_done_q ? 16'd0 : word_count_q) + 16'(out_valid_d);
    end

    // Statistics registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_count_q  <= '0;
            word_count_q <= '0;
        end else begin
            bit_count_q  <= bit_count_d;
            word_count_q <= word_count_d;
        end
    end

    assign bus.bit_count  = bit_count_q;
    assign bus.word_count = word_count_q;
`endif
endmodule

// File: tb/tb_vlc_bit_packer.sv
// tb_vlc_bit_packer: directed table vectors, corner sequences and a
// bit-queue reference model driven by random codeword/flush traffic.
module tb_vlc_bit_packer;
    logic clock = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    vlc_bit_packer_if bus ();

    vlc_bit_packer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic        en;
        logic        fl;
        logic [31:0] code;
        logic [5:0]  len;
        logic        v;
        logic [31:0] d;
        logic [2:0]  b;
        logic        fd;
        logic        bz;
        logic        er;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  b;
        logic        fd;
    } wexp_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic en, fl, input logic [31:0] code,
                                input logic [5:0] len, input logic v,
                                input logic [31:0] d, input logic [2:0] b,
                                input logic fd, bz, er);
        vec_t r;
        r.en = en; r.fl = fl; r.code = code; r.len = len;
        r.v = v; r.d = d; r.b = b; r.fd = fd; r.bz = bz; r.er = er;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic v, input logic [31:0] d,
                            input logic [2:0] b, input logic fd, bz, er);
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(v));
        chk({tag, ".out_data"}, 64'(bus.out_data), 64'(d));
        chk({tag, ".out_bytes"}, 64'(bus.out_bytes), 64'(b));
        chk({tag, ".flush_done"}, 64'(bus.flush_done), 64'(fd));
        chk({tag, ".busy"}, 64'(bus.busy), 64'(bz));
        chk({tag, ".len_error"}, 64'(bus.len_error), 64'(er));
    endtask

    task automatic drive(input logic en, fl, input logic [31:0] code, input logic [5:0] len);
        @(negedge clock);
        bus.vlc_enable = en;
        bus.vlc_flush  = fl;
        bus.vlc_code   = code;
        bus.vlc_length = len;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        bus.vlc_enable = 1'b0;
        bus.vlc_flush  = 1'b0;
        bus.vlc_code   = '0;
        bus.vlc_length = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        bit          q[$];
        wexp_t       pend[$];
        wexp_t       w;
        logic        m_err;
        logic        m_fd_prev;
        int          m_bits;
        int          m_words;
        logic        en, fl;
        logic [31:0] code;
        logic [5:0]  len;
        logic        ev, efd, ebz;
        logic [31:0] ed;
        logic [2:0]  eb;
        int          l, k, app;

        do_reset();
        reset_n = 1'b0;
        #1;
        chk_outs("reset", 0, 0, 0, 0, 0, 0);
`ifdef VLC_PACKER_STATS_EN
        chk("reset.bit_count", 64'(bus.bit_count), 0);
        chk("reset.word_count", 64'(bus.word_count), 0);
`endif
        @(negedge clock);
        reset_n = 1'b1;

        // eight nibbles of ones make one full word
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(1, 0, 32'hF, 4, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'hF, 4, 1, 32'hFFFF_FFFF, 4, 0, 0, 0));
        // zero length is a no-op; short residue flush
        tbl.push_back(mk(1, 0, 32'hFF, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'hFFFF_FFF5, 3, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 32'hA000_0000, 1, 1, 0, 0));
        // empty flush gives flush_done only
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        // 33-bit flush spills into a second word
        tbl.push_back(mk(1, 0, 32'h7FFF_FFFF, 31, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h3, 2, 1, 32'hFFFF_FFFF, 4, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 32'h8000_0000, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // over-length clamps to 32 and flags len_error
        tbl.push_back(mk(1, 0, 32'h1234_5678, 40, 1, 32'h1234_5678, 4, 0, 0, 1));
        tbl.push_back(mk(1, 0, 32'hFFFFF, 20, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 32'hFFFFF, 20, 1, 32'hFFFF_FFFF, 4, 0, 0, 1));
        // enable during the spill cycle is dropped
        tbl.push_back(mk(1, 0, 32'hAB, 8, 1, 32'hFF00_0000, 1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].fl, tbl[i].code, tbl[i].len);
            chk_outs($sformatf("tbl%0d", i), tbl[i].v, tbl[i].d, tbl[i].b,
                     tbl[i].fd, tbl[i].bz, tbl[i].er);
        end

        // reset while the spill word is pending
        do_reset();
        drive(1, 0, 32'hFFFFF, 20);
        drive(1, 1, 32'hFFFFF, 20);
        chk_outs("rst_pre", 1, 32'hFFFF_FFFF, 4, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_outs("rst_mid", 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(0, 0, 0, 0);
        chk_outs("rst_post1", 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk_outs("rst_post2", 0, 0, 0, 0, 0, 0);

`ifdef VLC_PACKER_STATS_EN
        // ten 5-bit codes: 50 bits, two words over the slice
        do_reset();
        for (int i = 0; i < 10; i++) drive(1, 0, 32'h15, 5);
        drive(0, 1, 0, 0);
        chk("stat.flush_done", 64'(bus.flush_done), 1);
        chk("stat.bit_count", 64'(bus.bit_count), 50);
        chk("stat.word_count", 64'(bus.word_count), 2);
        drive(0, 0, 0, 0);
        chk("stat.bit_clr", 64'(bus.bit_count), 0);
        chk("stat.word_clr", 64'(bus.word_count), 0);
`endif

        // random traffic against a bit-queue model
        do_reset();
        m_err = 0;
        m_fd_prev = 0;
        m_bits = 0;
        m_words = 0;
        for (int c = 0; c < 3000; c++) begin
            en   = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 14) == 0);
            code = $urandom;
            len  = ($urandom_range(0, 199) == 0) ? 6'($urandom_range(33, 63))
                                                 : 6'($urandom_range(0, 32));
            ev = 0; ed = 0; eb = 0; efd = 0; ebz = 0; app = 0;
            if (pend.size() > 0) begin
                w = pend.pop_front();
                ev = 1; ed = w.d; eb = w.b; efd = w.fd; ebz = 1;
                if (en || fl) m_err = 1;
            end else begin
                if (en) begin
                    l = (len > 32) ? 32 : int'(len);
                    if (len > 32) m_err = 1;
                    for (int i = l - 1; i >= 0; i--) q.push_back(code[i]);
                    app = l;
                end
                if (fl) begin
                    if (q.size() == 0) begin
                        efd = 1;
                    end else begin
                        while (q.size() > 0) begin
                            k = (q.size() > 32) ? 32 : q.size();
                            w.d = '0;
                            for (int i = 0; i < k; i++) w.d[31-i] = q.pop_front();
                            w.b = 3'((k + 7) / 8);
                            w.fd = 0;
                            pend.push_back(w);
                        end
                        pend[pend.size()-1].fd = 1;
                        w = pend.pop_front();
                        ev = 1; ed = w.d; eb = w.b; efd = w.fd;
                    end
                end else if (q.size() >= 32) begin
                    for (int i = 0; i < 32; i++) ed[31-i] = q.pop_front();
                    ev = 1; eb = 4;
                end
            end
            if (m_fd_prev) begin
                m_bits = 0;
                m_words = 0;
            end
            m_bits += app;
            m_words += int'(ev);
            m_fd_prev = efd;
            drive(en, fl, code, len);
            chk_outs($sformatf("rnd%0d", c), ev, ed, eb, efd, ebz, m_err);
`ifdef VLC_PACKER_STATS_EN
            chk($sformatf("rnd%0d.bit_count", c), 64'(bus.bit_count), 64'(m_bits));
            chk($sformatf("rnd%0d.word_count", c), 64'(bus.word_count), 64'(m_words));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/vlc_bit_packer.md
Name: vlc_bit_packer

Overview:
- Packs variable-length DC/AC codewords into a contiguous MSB-first 32-bit word stream for the slice output buffer.
- Sits directly downstream of the DC/AC VLC encoders.
- Driven by the slice sequencer's vlc output-enable and flush strobes.
- No backpressure; the sequencer timing guarantees the consumer accepts one word per cycle.

Parameters:
- WORD_W, 32, output word width; only 32 is supported.
- LEN_W, 6, width of the codeword length field; legal lengths are 0..32.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- vlc_code  in  32  codeword, right-aligned; bits above vlc_length are ignored
- vlc_length  in  LEN_W  number of valid code bits, 0..32
- vlc_enable  in  1  append vlc_code this cycle (tie to dc/ac_vlc_output_enable)
- vlc_flush  in  1  pad to a word boundary and emit the residue (tie to ac_vlc_output_flush)
- out_data  out  32  packed word; first code bit is at bit 31
- out_valid  out  1  out_data valid this cycle
- out_bytes  out  3  valid bytes in out_data: 4 for full words, 1..4 for the flushed residue
- flush_done  out  1  one-cycle pulse after the last word of a flush
- busy  out  1  high while in FLUSH2
- len_error  out  1  sticky; set when vlc_length > 32 is seen with vlc_enable

Behaviour:
- Decided: one clock; reset is asynchronous and active-low (clock, reset_n).
- Reset values:
  - out_data = 0, out_valid = 0, out_bytes = 0, flush_done = 0, busy = 0, len_error = 0.
  - Internal 64-bit accumulator acc = 0, fill = 0, state = RUN.
- Length and masking:
  - Masked code = vlc_code & ((1<<len)-1), where len = min(vlc_length, 32).
  - vlc_length > 32 clamps to 32 and sets len_error.
  - Length 0 with enable is a no-op.
- RUN, vlc_enable only:
  - Append: newfill = fill + len (max 63). Code bits are placed at acc[63-fill -: len].
  - If newfill >= 32: next cycle out_data = acc upper 32 bits, out_valid = 1, out_bytes = 4. Then shift acc left 32 and set fill = newfill - 32.
  - Otherwise out_valid = 0.
  - Latency is 1 cycle from the enable edge to out_valid.
- RUN, vlc_flush (with or without vlc_enable): append first if enabled, then evaluate newfill.
  - newfill == 0: no word; flush_done = 1 next cycle.
  - 0 < newfill <= 32: one word, zero-padded. out_bytes = ceil(newfill/8). flush_done = 1 in the same cycle as out_valid. fill = 0.
  - newfill > 32: first cycle emits a full word (out_bytes = 4) and enters FLUSH2.
- FLUSH2:
  - busy = 1.
  - Next cycle emits the residue, zero-padded, with out_bytes = ceil((newfill-32)/8), out_valid = 1, flush_done = 1.
  - Then fill = 0, acc = 0, return to RUN.
  - vlc_enable or vlc_flush during FLUSH2 is ignored and sets len_error.
- After any flush: acc = 0 and fill = 0, so the next slice starts word-aligned.
- Pulses: out_valid and flush_done are single-cycle; a continuous enable stream may give out_valid on consecutive cycles.
- Reset mid-operation: asserting reset_n low clears everything immediately (async), including a pending FLUSH2 word; that word is lost.
- len_error clears only on reset.

Optional Feature:
- Macro: VLC_PACKER_STATS_EN.
- Defined:
  - Adds output bit_count (32 bits): total code bits appended since the last flush_done, excluding padding. Holds its value through the flush_done cycle and clears on the cycle after.
  - Adds output word_count (16 bits): words emitted in the current slice, including flushed words. Cleared with the same timing.
  - Both reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Eight enables of code 0xF, length 4 -> one out_valid with out_data 0xFFFFFFFF, out_bytes 4, the cycle after the 8th enable; fill 0.
- Enable 0x5 len 3, then flush -> out_data 0xA0000000, out_bytes 1, flush_done in the same cycle.
- Enable 0x7FFFFFFF len 31, then same-cycle enable 0x3 len 2 plus flush -> word 0xFFFFFFFF, then next cycle 0x80000000 with out_bytes 1, busy high, flush_done high.
- Enable len 40 -> treated as 32 and len_error = 1; after a flush, enable during FLUSH2 -> ignored, len_error stays 1.
- Reset_n pulsed low during FLUSH2 -> all outputs 0 immediately; no residue word after release.
- With VLC_PACKER_STATS_EN: 10 codes of length 5 then flush -> bit_count 50 and word_count 2 at flush_done; both 0 the next cycle.
